// File: rtl/psum_pass_scheduler_if.sv
// rtl/psum_pass_scheduler_if.sv - handshake bundle between the SRAM controller side and the partial-sum pass scheduler
interface psum_pass_scheduler_if #(
  parameter int ROW    = 64,
  parameter int COL    = 64,
  parameter int NUM_PS = 8
);
  localparam int RW  = $clog2(ROW);
  localparam int CLW = $clog2(COL);
  localparam int PW  = $clog2(NUM_PS);

  logic           start;
  logic           w_req;
  logic           w_valid;
  logic [1:0]     w_fcol;
  logic [1:0]     w_prow;
  logic           fm_rd_en;
  logic           fm_ready;
  logic [RW-1:0]  fm_row;
  logic [CLW-1:0] fm_col;
  logic           psum_valid;
  logic           psum_first;
  logic           psum_last;
  logic [PW-1:0]  partial_sum_index;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    output start, w_valid, fm_ready, psum_valid,
    input  w_req, w_fcol, w_prow, fm_rd_en, fm_row, fm_col,
           psum_first, psum_last, partial_sum_index, busy, done, err
  );

  modport slave (
    input  start, w_valid, fm_ready, psum_valid,
    output w_req, w_fcol, w_prow, fm_rd_en, fm_row, fm_col,
           psum_first, psum_last, partial_sum_index, busy, done, err
  );
endinterface

// File: rtl/psum_pass_scheduler.sv
// rtl/psum_pass_scheduler.sv - sequences NUM_PS partial-sum passes: weight load, snake-order feature-map stream, output count
module psum_pass_scheduler #(
  parameter int ROW    = 64,
  parameter int COL    = 64,
  parameter int NUM_PS = 8
) (
  input logic               clk,
  input logic               rst,
  psum_pass_scheduler_if.slave bus
);
  localparam int OUT_CNT = ROW * COL;
  localparam int RW      = $clog2(ROW);
  localparam int CLW     = $clog2(COL);
  localparam int PW      = $clog2(NUM_PS);
  localparam int CW      = $clog2(OUT_CNT + 1);

  localparam logic [RW-1:0]  ROW_LAST  = RW'(ROW - 1);
  localparam logic [RW-1:0]  ROW_TWO   = RW'(2);
  localparam logic [CLW-1:0] COL_LAST  = CLW'(COL - 1);
  localparam logic [PW-1:0]  PS_LAST   = PW'(NUM_PS - 1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(OUT_CNT);
  localparam logic [CW-1:0]  CNT_PRE   = CW'(OUT_CNT - 1);
  localparam logic [1:0]     FCOL_LAST = 2'd3;
  localparam logic [1:0]     PROW_LAST = 2'd2;

  typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, NEXT, FIN} state_t;

  state_t         state;
  logic           w_req_q;
  logic           fm_rd_en_q;
  logic           done_q;
  logic           busy_q;
  logic           err_q;
  logic [1:0]     fcol;
  logic [1:0]     prow;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic [PW-1:0]  ps_idx;
  logic [CW-1:0]  out_cnt;

  logic           counting;
  logic           last_pix;
  logic           cnt_hit;

  // Each row ends on col 0 when even (walks down) and on COL-1 when odd.
  always_comb begin
    counting = (state == STREAM) || (state == DRAIN);
    last_pix = (row == ROW_LAST) && (col == (row[0] ? COL_LAST : '0));
    cnt_hit  = counting && bus.psum_valid && (out_cnt == CNT_PRE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      w_req_q    <= 1'b0;
      fm_rd_en_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      fcol       <= '0;
      prow       <= '0;
      row        <= '0;
      col        <= '0;
      ps_idx     <= '0;
      out_cnt    <= '0;
    end else begin
      done_q <= 1'b0;

      if (bus.w_valid && (state != WLOAD)) err_q <= 1'b1;
      if (bus.psum_valid && !counting) err_q <= 1'b1;

      // An output beyond OUT_CNT is flagged and dropped; the count never wraps.
      if (counting && bus.psum_valid) begin
        if (out_cnt == CNT_FULL) err_q <= 1'b1;
        else                     out_cnt <= out_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= WLOAD;
            ps_idx  <= '0;
            w_req_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        WLOAD: begin
          if (bus.w_valid) begin
            if (prow == PROW_LAST) begin
              prow <= '0;
              if (fcol == FCOL_LAST) begin
                fcol       <= '0;
                state      <= STREAM;
                w_req_q    <= 1'b0;
                fm_rd_en_q <= 1'b1;
              end else begin
                fcol <= fcol + 1'b1;
              end
            end else begin
              prow <= prow + 1'b1;
            end
          end
        end

        STREAM: begin
          if (bus.fm_ready && !last_pix) begin
            if (row < ROW_TWO) begin
              // Column-major zig over rows 0/1, leaving at (1, COL-1) into row 2.
              if (row == '0) begin
                row <= row + 1'b1;
              end else if (col == COL_LAST) begin
                row <= row + 1'b1;
              end else begin
                row <= '0;
                col <= col + 1'b1;
              end
            end else if (!row[0]) begin
              if (col == '0) row <= row + 1'b1;
              else           col <= col - 1'b1;
            end else begin
              if (col == COL_LAST) row <= row + 1'b1;
              else                 col <= col + 1'b1;
            end
          end

          if (cnt_hit) begin
            state      <= NEXT;
            fm_rd_en_q <= 1'b0;
          end else if (bus.fm_ready && last_pix) begin
            state      <= DRAIN;
            fm_rd_en_q <= 1'b0;
          end
        end

        DRAIN: begin
          if (cnt_hit) state <= NEXT;
        end

        NEXT: begin
          out_cnt <= '0;
          row     <= '0;
          col     <= '0;
          if (ps_idx == PS_LAST) begin
            state  <= FIN;
            done_q <= 1'b1;
          end else begin
            ps_idx  <= ps_idx + 1'b1;
            state   <= WLOAD;
            w_req_q <= 1'b1;
          end
        end

        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          ps_idx <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.w_req             = w_req_q;
  assign bus.w_fcol            = fcol;
  assign bus.w_prow            = prow;
  assign bus.fm_rd_en          = fm_rd_en_q;
  assign bus.fm_row            = row;
  assign bus.fm_col            = col;
  assign bus.psum_first        = busy_q && (ps_idx == '0);
  assign bus.psum_last         = busy_q && (ps_idx == PS_LAST);
  assign bus.partial_sum_index = ps_idx;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.err               = err_q;
endmodule

// File: tb/tb_psum_pass_scheduler.sv
// tb/tb_psum_pass_scheduler.sv - randomized directed bench for psum_pass_scheduler against a pass-level reference model
module tb_psum_pass_scheduler;
  localparam int ROW     = 4;
  localparam int COL     = 4;
  localparam int NUM_PS  = 2;
  localparam int PIX     = ROW * COL;
  localparam int OUT_CNT = ROW * COL;
  localparam int W_BEATS = 12;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic errx;
  bit   ab;
  int   exp_row [PIX];
  int   exp_col [PIX];

  psum_pass_scheduler_if #(.ROW(ROW), .COL(COL), .NUM_PS(NUM_PS)) bus ();

  psum_pass_scheduler #(.ROW(ROW), .COL(COL), .NUM_PS(NUM_PS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_w_req"}, bus.w_req, 0);
    chk({tag, "_fm_rd_en"}, bus.fm_rd_en, 0);
    chk({tag, "_first"}, bus.psum_first, 0);
    chk({tag, "_last"}, bus.psum_last, 0);
    chk({tag, "_psi"}, bus.partial_sum_index, 0);
    chk({tag, "_coord"}, {bus.fm_row, bus.fm_col, bus.w_fcol, bus.w_prow}, 0);
  endtask

  task automatic chk_pass(input int pass);
    chk("busy", bus.busy, 1);
    chk("done_mid", bus.done, 0);
    chk("err", bus.err, errx);
    chk("psi", bus.partial_sum_index, pass);
    chk("psum_first", bus.psum_first, pass == 0);
    chk("psum_last", bus.psum_last, pass == NUM_PS - 1);
  endtask

  // inj bits: 1 psum in WLOAD, 2 w_valid in STREAM, 4 psum after the 16th, 8 start while busy, 16 reset at pixel 7
  task automatic run_pass(input int pass, input int fm_mode, input int gap_mode, input int inj, output bit aborted);
    int  p, s, g, cyc, fr_i;
    bit  fr, pv, wv_done, st_done;
    aborted = 0;
    for (int b = 0; b < W_BEATS; b++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : int'($urandom_range(0, 3));
      for (int k = 0; k <= g; k++) begin
        @(negedge clk);
        bus.start = 0;
        bus.fm_ready = 0;
        bus.psum_valid = 0;
        chk_pass(pass);
        chk("w_req", bus.w_req, 1);
        chk("fm_rd_en_wl", bus.fm_rd_en, 0);
        chk("w_fcol", bus.w_fcol, b / 3);
        chk("w_prow", bus.w_prow, b % 3);
        bus.w_valid = (k == g);
        if ((inj & 1) != 0 && b == 5 && k == g) begin
          bus.psum_valid = 1;
          errx = 1;
        end
      end
    end

    p = 0; s = 0; cyc = 0; fr_i = 0; wv_done = 0; st_done = 0;
    while (s < OUT_CNT) begin
      @(negedge clk);
      bus.w_valid = 0;
      bus.start = 0;
      cyc++;
      if (cyc > 3000) begin
        total++;
        bad++;
        $error("FAIL stream_timeout observed=%0d outputs expected=%0d", s, OUT_CNT);
        return;
      end
      chk_pass(pass);
      chk("w_req_st", bus.w_req, 0);
      chk("fm_rd_en", bus.fm_rd_en, p < PIX);
      if (p < PIX) begin
        chk("fm_row", bus.fm_row, exp_row[p]);
        chk("fm_col", bus.fm_col, exp_col[p]);
      end
      if ((inj & 16) != 0 && p == 7) begin
        rst = 1;
        bus.fm_ready = 0;
        bus.psum_valid = 0;
        @(negedge clk);
        errx = 0;
        chk_zero("abort");
        rst = 0;
        aborted = 1;
        return;
      end
      case (fm_mode)
        0:       fr = 1;
        1:       fr = (fr_i % 3 == 0);
        default: fr = ($urandom_range(0, 1) == 1);
      endcase
      fr_i++;
      pv = (s < p + ((fr && p < PIX) ? 1 : 0)) && ($urandom_range(0, 3) != 0);
      bus.fm_ready = fr;
      bus.psum_valid = pv;
      if ((inj & 2) != 0 && p == 5 && !wv_done) begin
        bus.w_valid = 1;
        errx = 1;
        wv_done = 1;
      end
      if ((inj & 8) != 0 && p == 9 && !st_done) begin
        bus.start = 1;
        st_done = 1;
      end
      if (fr && p < PIX) p++;
      if (pv) s++;
    end

    @(negedge clk);
    bus.psum_valid = 0;
    bus.fm_ready = 0;
    bus.w_valid = 0;
    bus.start = 0;
    chk_pass(pass);
    chk("w_req_next", bus.w_req, 0);
    chk("fm_rd_en_next", bus.fm_rd_en, 0);
    if ((inj & 4) != 0) begin
      bus.psum_valid = 1;
      errx = 1;
    end
  endtask

  task automatic run_layer(input int fm_mode, input int gap_mode, input int inj0, input int inj1, output bit aborted);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_err", bus.err, errx);
    bus.start = 1;
    for (int ps = 0; ps < NUM_PS; ps++) begin
      run_pass(ps, fm_mode, gap_mode, (ps == 0) ? inj0 : inj1, aborted);
      if (aborted) return;
    end
    @(negedge clk);
    bus.psum_valid = 0;
    chk("fin_done", bus.done, 1);
    chk("fin_busy", bus.busy, 1);
    chk("fin_last", bus.psum_last, 1);
    chk("fin_err", bus.err, errx);
    @(negedge clk);
    chk("post_done", bus.done, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_first", bus.psum_first, 0);
    chk("post_last", bus.psum_last, 0);
    chk("post_psi", bus.partial_sum_index, 0);
    chk("post_err", bus.err, errx);
  endtask

  initial begin
    int k;
    k = 0;
    for (int c = 0; c < COL; c++)
      for (int r = 0; r < 2; r++) begin
        exp_row[k] = r;
        exp_col[k] = c;
        k++;
      end
    for (int r = 2; r < ROW; r++)
      for (int j = 0; j < COL; j++) begin
        exp_row[k] = r;
        exp_col[k] = (r % 2 == 0) ? COL - 1 - j : j;
        k++;
      end

    rst = 1;
    bus.start = 0;
    bus.w_valid = 0;
    bus.fm_ready = 0;
    bus.psum_valid = 0;
    errx = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;

    run_layer(0, 0, 0, 0, ab);
    run_layer(1, 1, 0, 0, ab);
    run_layer(2, 2, 8, 0, ab);
    run_layer(2, 2, 1 | 2, 4, ab);

    @(negedge clk);
    rst = 1;
    @(negedge clk);
    errx = 0;
    chk_zero("err_clear");
    rst = 0;

    run_layer(2, 2, 0, 16, ab);
    run_layer(2, 2, 0, 0, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_pass_scheduler.md
Name: psum_pass_scheduler

Overview:
- Sequences layer-2 execution of the PE array as NUM_PS partial-sum passes, one per input-channel group.
- Each pass loads the 12 weight beats for its group, streams the feature map in the array's snake order, and counts partial-sum outputs until the pass completes.
- Tells the accumulator whether to overwrite or add, and drives partial_sum_index.
- Sits between the SRAM controller (layer start, feature-map reads, weight fetch) and the chip datapath.

Parameters:
- ROW, 64: feature-map rows per pass.
- COL, 64: feature-map columns per pass.
- NUM_PS, 8: partial-sum passes per layer.
- W_BEATS, 12: weight beats per pass (4 filter_col x 3 PEA_row).
- OUT_CNT, ROW*COL: partial-sum outputs expected per pass.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a layer; ignored unless IDLE.
- w_req  out  1  weight fetch request for the current pass.
- w_valid  in  1  one weight beat is present on the datapath this cycle.
- w_fcol  out  2  filter_col of the beat expected next.
- w_prow  out  2  PEA_row of the beat expected next.
- fm_rd_en  out  1  feature-map read request.
- fm_ready  in  1  read accepted this cycle (fm_rd_en && fm_ready = 1 pixel).
- fm_row  out  $clog2(ROW)  row of the current pixel.
- fm_col  out  $clog2(COL)  column of the current pixel.
- psum_valid  in  1  one partial-sum output from the array.
- psum_first  out  1  accumulator overwrites (pass 0) instead of adding.
- psum_last  out  1  current pass is NUM_PS-1; accumulator result is final.
- partial_sum_index  out  $clog2(NUM_PS)  current pass number.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer completes.
- err  out  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. rst mid-operation aborts to IDLE the next cycle; nothing is preserved.
- States: IDLE, WLOAD, STREAM, DRAIN, NEXT, FIN.
- IDLE:
  - start -> WLOAD with partial_sum_index=0.
  - start while busy is ignored and does not set err.
- WLOAD:
  - w_req=1.
  - Beat counter advances on each w_valid; order is filter_col outer 0..3, PEA_row inner 0..2.
  - w_fcol/w_prow show the beat expected next.
  - 12th beat -> STREAM next cycle; w_req drops that same cycle.
- STREAM:
  - fm_rd_en=1; the pixel advances only on fm_ready.
  - Phase A: col 0..COL-1; within each col, row 0 then row 1.
  - Phase B: rows 2..ROW-1; even rows walk col COL-1 down to 0, odd rows walk col 0 up to COL-1.
  - Accepting pixel (ROW-1, end col of that row) -> DRAIN; fm_rd_en drops the next cycle.
- Output counting (STREAM and DRAIN):
  - Output counter increments on psum_valid; psum_valid may arrive while STREAM is still running.
  - Count reaching OUT_CNT -> NEXT. If this coincides with the final pixel acceptance in STREAM, go to NEXT directly.
- NEXT (one cycle):
  - Output and pixel counters clear.
  - If partial_sum_index==NUM_PS-1 -> FIN; else increment partial_sum_index -> WLOAD.
- FIN: done=1 for one cycle -> IDLE.
- Accumulator flags: psum_first = (partial_sum_index==0) && busy; psum_last = (partial_sum_index==NUM_PS-1) && busy. Both are stable across a pass.
- err is set by any of:
  - psum_valid in IDLE, WLOAD, NEXT or FIN;
  - w_valid outside WLOAD;
  - psum_valid in the cycle the count is already OUT_CNT.
- Offending events are otherwise ignored; the counter saturates and does not wrap.
- No combinational path from inputs to fm_rd_en or w_req; both are registered from state.
- psum_valid and fm_ready in the same cycle are handled independently.

Test Plan (ROW=4, COL=4, NUM_PS=2, OUT_CNT=16):
- Snake order: start, 12 back-to-back w_valid, fm_ready tied 1 -> exactly 16 fm_rd_en&&fm_ready cycles in order (0,0)(1,0)(0,1)(1,1)(0,2)(1,2)(0,3)(1,3)(2,3)(2,2)(2,1)(2,0)(3,0)(3,1)(3,2)(3,3). w_fcol/w_prow sequence 0/0,0/1,0/2,1/0…3/2.
- Full layer: 16 psum_valid per pass, with the first arriving during STREAM -> partial_sum_index goes 0 then 1. psum_first=1 only in pass 0; psum_last=1 only in pass 1. A single done pulse follows the 32nd psum_valid by 2 cycles; err=0.
- Backpressure: fm_ready toggles 1,0,0,1,… -> coordinates hold while fm_ready=0, no pixel skipped or repeated; w_valid gaps of 3 cycles -> w_req stays 1 until the 12th beat.
- Errors: psum_valid during WLOAD -> err=1 and the count stays 0; 17th psum_valid in a pass -> err=1 and the count stays 16; w_valid in STREAM -> err=1 and the pixel sequence is unaffected.
- Mid-op reset: rst at pixel 7 of pass 1 -> next cycle all outputs 0 and busy=0. A new start then re-runs pass 0 from (0,0) with partial_sum_index=0 and err=0.
- Start while busy: start pulsed during STREAM -> no state change and no err; done still pulses once.
